// File: rtl/snurisc_mem_pkg.sv
// Shared types and constants for the snurisc memory arbiter and its
// round-robin picker.
package snurisc_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Owner encoding doubles as the bit index into the 2-bit request/grant vectors.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/snurisc_rr_arb2.sv
// Two-requester round-robin picker. Grant is combinational from the request
// vector; last_owner only moves when the caller accepts a grant via advance.
module snurisc_rr_arb2
  import snurisc_mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic last_owner_q;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (last_owner_q == OWN_D) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Reset favours the I side first by pretending D was the last winner.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_owner_q <= OWN_D;
    end else if (i_advance && (o_gnt != 2'b00)) begin
      last_owner_q <= o_gnt[OWN_D];
    end
  end

endmodule

// File: rtl/snurisc_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch (I) and data (D)
// ports: round-robin grant, one outstanding access, grant->rvalid = MEM_LAT+2.
module snurisc_mem_arbiter
  import snurisc_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_imem_req,
  input  logic [ADDR_W-1:0]   i_imem_addr,
  output logic                o_imem_gnt,
  output logic                o_imem_rvalid,
  output logic [DATA_W-1:0]   o_imem_rdata,
  input  logic                i_dmem_req,
  input  logic                i_dmem_we,
  input  logic [ADDR_W-1:0]   i_dmem_addr,
  input  logic [DATA_W-1:0]   i_dmem_wdata,
  input  logic [DATA_W/8-1:0] i_dmem_be,
  output logic                o_dmem_gnt,
  output logic                o_dmem_rvalid,
  output logic [DATA_W-1:0]   o_dmem_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy,
  output logic [1:0]          o_dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  // Handshake: a port holds req (with stable fields) until its one-cycle gnt;
  // fields are sampled only on the gnt edge. rvalid is a one-cycle pulse and
  // rdata holds its value between pulses.

  state_e              state_q;
  logic                owner_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                imem_rvalid_q;
  logic [DATA_W-1:0]   imem_rdata_q;
  logic                dmem_rvalid_q;
  logic [DATA_W-1:0]   dmem_rdata_q;

  logic                idle;
  logic [1:0]          arb_gnt;
  logic                grant_any;

  // Gating with reset keeps the combinational grants quiet while reset is held.
  assign idle = (state_q == ST_IDLE) && i_reset_n;

  snurisc_rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     ({i_dmem_req, i_imem_req}),
    .i_advance (idle),
    .o_gnt     (arb_gnt)
  );

  assign o_imem_gnt = idle & arb_gnt[OWN_I];
  assign o_dmem_gnt = idle & arb_gnt[OWN_D];
  assign grant_any  = o_imem_gnt | o_dmem_gnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_I;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      imem_rvalid_q <= 1'b0;
      imem_rdata_q  <= '0;
      dmem_rvalid_q <= 1'b0;
      dmem_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            owner_q  <= o_dmem_gnt ? OWN_D : OWN_I;
            mem_en_q <= 1'b1;
            if (o_dmem_gnt) begin
              we_q        <= i_dmem_we;
              mem_we_q    <= i_dmem_we;
              mem_addr_q  <= i_dmem_addr;
              mem_wdata_q <= i_dmem_wdata;
              mem_be_q    <= i_dmem_be;
            end else begin
              we_q        <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_imem_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_be_q    <= '0;
          cnt_q       <= CNT_W'(MEM_LAT);
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // cnt_q==1 is the cycle the memory presents read data.
          if (cnt_q == CNT_W'(1)) begin
            if (owner_q == OWN_D) begin
              dmem_rvalid_q <= 1'b1;
              dmem_rdata_q  <= we_q ? '0 : i_mem_rdata;
            end else begin
              imem_rvalid_q <= 1'b1;
              imem_rdata_q  <= i_mem_rdata;
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          imem_rvalid_q <= 1'b0;
          dmem_rvalid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_rvalid = imem_rvalid_q;
  assign o_imem_rdata  = imem_rdata_q;
  assign o_dmem_rvalid = dmem_rvalid_q;
  assign o_dmem_rdata  = dmem_rdata_q;
  assign o_mem_en      = mem_en_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_mem_be      = mem_be_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_snurisc_mem_arbiter.sv
// Bench for snurisc_mem_arbiter: three builds (MEM_LAT 2, 1, 5) share one
// stimulus stream and are each checked cycle-by-cycle against a transaction model.
module tb_snurisc_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_mode  = 1'b0;
  bit hold_mode = 1'b0;

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
  endfunction

  function automatic logic [31:0] mem_init(int i);
    if (i == 64) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge_be(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUT signals (one slot per build) ----------------
  logic [2:0]  imem_req, dmem_req, dmem_we;
  logic [31:0] imem_addr [3];
  logic [31:0] dmem_addr [3];
  logic [31:0] dmem_wdata [3];
  logic [3:0]  dmem_be [3];
  logic [2:0]  imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, mem_en, mem_we, busy;
  logic [31:0] imem_rdata [3];
  logic [31:0] dmem_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_be [3];
  logic [1:0]  dbg_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    logic [31:0] mem_rdata;

    snurisc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_imem_req    (imem_req[g]),
      .i_imem_addr   (imem_addr[g]),
      .o_imem_gnt    (imem_gnt[g]),
      .o_imem_rvalid (imem_rvalid[g]),
      .o_imem_rdata  (imem_rdata[g]),
      .i_dmem_req    (dmem_req[g]),
      .i_dmem_we     (dmem_we[g]),
      .i_dmem_addr   (dmem_addr[g]),
      .i_dmem_wdata  (dmem_wdata[g]),
      .i_dmem_be     (dmem_be[g]),
      .o_dmem_gnt    (dmem_gnt[g]),
      .o_dmem_rvalid (dmem_rvalid[g]),
      .o_dmem_rdata  (dmem_rdata[g]),
      .o_mem_en      (mem_en[g]),
      .o_mem_we      (mem_we[g]),
      .o_mem_addr    (mem_addr[g]),
      .o_mem_wdata   (mem_wdata[g]),
      .o_mem_be      (mem_be[g]),
      .i_mem_rdata   (mem_rdata),
      .o_busy        (busy[g]),
      .o_dbg_state   (dbg_state[g])
    );

    // Memory responder: data appears exactly LAT cycles after the o_mem_en
    // cycle; every other cycle the bus carries random junk.
    logic [31:0] rmem [256];
    bit          rinit = 1'b0;
    int          rcyc  = 0;
    int          pend  = -1;
    logic [31:0] pdata;
    always @(negedge clk) begin
      if (!rinit) begin
        for (int i = 0; i < 256; i++) rmem[i] = mem_init(i);
        rinit = 1'b1;
      end
      rcyc++;
      if (!rst_n) pend = -1;
      mem_rdata = (rcyc == pend) ? pdata : $urandom();
      if (rst_n && mem_en[g]) begin
        if (mem_we[g]) rmem[mem_addr[g][9:2]] = merge_be(rmem[mem_addr[g][9:2]], mem_wdata[g], mem_be[g]);
        pdata = rmem[mem_addr[g][9:2]];
        pend  = rcyc + LAT;
      end
    end

    // ---------------- scoreboard / reference model ----------------
    // Transaction view: a grant at cycle t0 means mem access at t0+1, response
    // at t0+2+LAT, next grant possible from t0+3+LAT.
    logic [31:0] smem [256];
    bit          sinit = 1'b0;
    int          cyc = 0, t0 = 0;
    bit          act = 1'b0, last_d = 1'b1, own_d = 1'b0;
    logic [31:0] trd, twd, last_ird = '0, last_drd = '0;
    logic [37:0] tctl;
    always @(negedge clk) begin
      logic        eig, edg, eirv, edrv, ebusy, chk_wd;
      logic [37:0] ectl;
      logic [31:0] ewd, eird, edrd;
      logic [7:0]  idx;
      if (!sinit) begin
        for (int i = 0; i < 256; i++) smem[i] = mem_init(i);
        sinit = 1'b1;
      end
      cyc++;
      eig = 0; edg = 0; eirv = 0; edrv = 0; ebusy = 0; chk_wd = 1;
      ectl = '0; ewd = '0; eird = last_ird; edrd = last_drd;
      if (!rst_n) begin
        act = 0; last_d = 1; last_ird = '0; last_drd = '0; eird = '0; edrd = '0;
      end else if (act) begin
        ebusy = (cyc > t0);
        if (cyc == t0 + 1) begin
          ectl = tctl; ewd = twd; chk_wd = own_d;
        end
        if (cyc == t0 + 2 + LAT) begin
          if (own_d) begin edrv = 1; edrd = trd; end
          else       begin eirv = 1; eird = trd; end
        end
      end else if (imem_req[g] || dmem_req[g]) begin
        own_d  = dmem_req[g] && (!imem_req[g] || !last_d);
        last_d = own_d;
        eig = !own_d; edg = own_d;
        if (own_d) begin
          idx  = dmem_addr[g][9:2];
          trd  = dmem_we[g] ? 32'h0 : smem[idx];
          tctl = {1'b1, dmem_we[g], dmem_addr[g], dmem_be[g]};
          twd  = dmem_wdata[g];
          if (dmem_we[g]) smem[idx] = merge_be(smem[idx], dmem_wdata[g], dmem_be[g]);
        end else begin
          idx  = imem_addr[g][9:2];
          trd  = smem[idx];
          tctl = {1'b1, 1'b0, imem_addr[g], 4'hF};
          twd  = '0;
        end
        act = 1; t0 = cyc;
      end
      check($sformatf("L%0d.imem_gnt", LAT), imem_gnt[g], eig);
      check($sformatf("L%0d.dmem_gnt", LAT), dmem_gnt[g], edg);
      check($sformatf("L%0d.mem_ctl", LAT), {mem_en[g], mem_we[g], mem_addr[g], mem_be[g]}, ectl);
      if (chk_wd) check($sformatf("L%0d.mem_wdata", LAT), mem_wdata[g], ewd);
      check($sformatf("L%0d.imem_rvalid", LAT), imem_rvalid[g], eirv);
      check($sformatf("L%0d.dmem_rvalid", LAT), dmem_rvalid[g], edrv);
      check($sformatf("L%0d.imem_rdata", LAT), imem_rdata[g], eird);
      check($sformatf("L%0d.dmem_rdata", LAT), dmem_rdata[g], edrd);
      check($sformatf("L%0d.busy", LAT), busy[g], ebusy);
      if (act && cyc == t0 + 2 + LAT) begin
        act = 0; last_ird = eird; last_drd = edrd;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: observe outputs mid-cycle, then after the edge retire granted
  // requests and (in random mode) create new ones or withdraw pending ones.
  task automatic step(output logic [2:0] ig, output logic [2:0] dg,
                      output logic [2:0] irv, output logic [2:0] drv);
    @(negedge clk);
    ig = imem_gnt; dg = dmem_gnt; irv = imem_rvalid; drv = dmem_rvalid;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      if (!hold_mode) begin
        if (ig[g]) imem_req[g] = 1'b0;
        if (dg[g]) dmem_req[g] = 1'b0;
      end
      if (rnd_mode) begin
        if (!imem_req[g]) begin
          if ($urandom_range(0, 2) == 0) begin
            imem_req[g] = 1'b1; imem_addr[g] = $urandom();
          end
        end else if ($urandom_range(0, 15) == 0) imem_req[g] = 1'b0;
        if (!dmem_req[g]) begin
          if ($urandom_range(0, 2) == 0) begin
            dmem_req[g] = 1'b1; dmem_we[g] = 1'($urandom_range(0, 1));
            dmem_addr[g] = $urandom(); dmem_wdata[g] = $urandom();
            dmem_be[g] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 15) == 0) dmem_req[g] = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    logic [2:0] ig, dg, irv, drv;
    repeat (n) step(ig, dg, irv, drv);
  endtask

  // Same request on every build; measures grant->rvalid and checks the data.
  task automatic run_single(input string tag, input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd);
    logic [2:0] ig, dg, irv, drv;
    int tg [3];
    int tr [3];
    for (int g = 0; g < 3; g++) begin
      tg[g] = -1; tr[g] = -1;
      if (is_d) begin
        dmem_req[g] = 1'b1; dmem_we[g] = we; dmem_addr[g] = addr; dmem_wdata[g] = wd; dmem_be[g] = be;
      end else begin
        imem_req[g] = 1'b1; imem_addr[g] = addr;
      end
    end
    for (int c = 0; c < 20; c++) begin
      step(ig, dg, irv, drv);
      for (int g = 0; g < 3; g++) begin
        if ((is_d ? dg[g] : ig[g]) && tg[g] < 0) tg[g] = c;
        if ((is_d ? drv[g] : irv[g]) && tr[g] < 0) tr[g] = c;
      end
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s.L%0d.latency", tag, lat_of(g)), tr[g] - tg[g], lat_of(g) + 2);
      check($sformatf("%s.L%0d.rdata", tag, lat_of(g)), is_d ? dmem_rdata[g] : imem_rdata[g], exp_rd);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [0:0] exp_q [$];
  logic [0:0] got_q [$];
  int         gcyc_q [$];

  initial begin
    logic [2:0] ig, dg, irv, drv;
    int tg, td, nrv;
    imem_req = '0; dmem_req = '0; dmem_we = '0;
    for (int g = 0; g < 3; g++) begin
      imem_addr[g] = '0; dmem_addr[g] = '0; dmem_wdata[g] = '0; dmem_be[g] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    idle_cycles(20);

    run_single("iread", 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF);
    run_single("dwrite", 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 32'h0);
    run_single("dread", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF,
               (mem_init(128) & 32'hFFFF_0000) | 32'h0000_5678);

    // Both ports requesting continuously from reset release.
    @(posedge clk); #1 rst_n = 1'b0;
    hold_mode = 1'b1;
    imem_req = 3'b111; dmem_req = 3'b111; dmem_we = 3'b000;
    for (int g = 0; g < 3; g++) begin imem_addr[g] = 32'h80; dmem_addr[g] = 32'h84; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 25; c++) begin
      step(ig, dg, irv, drv);
      if (ig[0]) begin got_q.push_back(1'b0); gcyc_q.push_back(c); end
      if (dg[0]) begin got_q.push_back(1'b1); gcyc_q.push_back(c); end
    end
    hold_mode = 1'b0; imem_req = '0; dmem_req = '0;
    check("fair.count_ge4", got_q.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check($sformatf("fair.owner%0d", i), got_q[i], exp_q.pop_front());
      if (i > 0) check($sformatf("fair.spacing%0d", i), gcyc_q[i] - gcyc_q[i-1], 5);
    end
    idle_cycles(12);

    // D request arriving during an I transaction's WAIT phase.
    tg = -1; td = -1;
    imem_req = 3'b111;
    for (int g = 0; g < 3; g++) imem_addr[g] = 32'h40;
    for (int c = 0; c < 30; c++) begin
      step(ig, dg, irv, drv);
      if (ig[0] && tg < 0) tg = c;
      if (tg >= 0 && c == tg + 1) begin
        dmem_req = 3'b111; dmem_we = 3'b000;
        for (int g = 0; g < 3; g++) dmem_addr[g] = 32'h44;
      end
      if (dg[0] && td < 0) td = c;
    end
    check("dwait.gnt_delay", td - tg, 5);

    // Reset asserted while a read is waiting on memory.
    tg = -1;
    imem_req = 3'b111;
    for (int g = 0; g < 3; g++) imem_addr[g] = 32'h100;
    for (int c = 0; c < 20 && tg < 0; c++) begin
      step(ig, dg, irv, drv);
      if (ig[0]) tg = c;
    end
    check("rstwait.granted", tg >= 0, 1'b1);
    step(ig, dg, irv, drv);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rstwait.L%0d.ctl", lat_of(g)),
            {imem_gnt[g], dmem_gnt[g], imem_rvalid[g], dmem_rvalid[g], mem_en[g], mem_we[g], busy[g], mem_be[g]}, '0);
      check($sformatf("rstwait.L%0d.data", lat_of(g)),
            {mem_addr[g], mem_wdata[g], imem_rdata[g], dmem_rdata[g]}, '0);
    end
    imem_req = '0; dmem_req = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nrv = 0;
    for (int c = 0; c < 12; c++) begin
      step(ig, dg, irv, drv);
      nrv += $countones({irv, drv});
    end
    check("rstwait.no_rvalid", nrv, 0);

    // Randomized traffic with withdrawals, writes and random byte enables.
    rnd_mode = 1'b1;
    idle_cycles(1500);
    rnd_mode = 1'b0;
    imem_req = '0; dmem_req = '0;
    idle_cycles(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snurisc_mem_arbiter.md
Name: snurisc_mem_arbiter

Overview:
- Shares one single-port, fixed-latency backing memory between the core's instruction-fetch port (I$ side) and data-access port (D$ side).
- Sits inside snurisc_top between the core memory ports and the memory model.
- Round-robin arbitration with one outstanding transaction at a time.
- Sequences each access: grant, issue, fixed-latency wait, response.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; DATA_W/8 byte enables.
- MEM_LAT, 2, cycles from the o_mem_en cycle to the cycle i_mem_rdata is valid; legal range >=1.

Ports:
- i_clk  in  1  clock; all state on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_imem_req  in  1  fetch request; held until o_imem_gnt.
- i_imem_addr  in  ADDR_W  fetch address.
- o_imem_gnt  out  1  one-cycle grant pulse.
- o_imem_rvalid  out  1  one-cycle response pulse.
- o_imem_rdata  out  DATA_W  fetch data, valid with o_imem_rvalid.
- i_dmem_req  in  1  data request; held until o_dmem_gnt.
- i_dmem_we  in  1  1 = write.
- i_dmem_addr  in  ADDR_W  data address.
- i_dmem_wdata  in  DATA_W  write data.
- i_dmem_be  in  DATA_W/8  byte enables.
- o_dmem_gnt  out  1  one-cycle grant pulse.
- o_dmem_rvalid  out  1  completion pulse for reads and writes.
- o_dmem_rdata  out  DATA_W  read data; 0 for write completions.
- o_mem_en  out  1  memory access strobe, one cycle.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- o_mem_be  out  DATA_W/8  memory byte enables.
- i_mem_rdata  in  DATA_W  valid MEM_LAT cycles after the o_mem_en cycle.
- o_busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE, wait counter=0, last_owner=D.
  - All o_* outputs 0, including captured address/data registers.
  - Any in-flight transaction is dropped; no rvalid is produced for it after reset releases.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any request is pending, the grant is combinational in the same cycle T.
  - Both requesting: grant the port != last_owner.
  - One requesting: grant that port.
  - At the T edge: latch owner, we, addr, wdata, be (I-port forces we=0 and be=all-ones); update last_owner; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (cycle T+1):
  - o_mem_en=1; o_mem_we/addr/wdata/be driven from the latched fields.
  - Counter loads MEM_LAT; go to WAIT.
  - o_mem_* are 0 in every cycle except ISSUE.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter==1 (cycle T+1+MEM_LAT), capture i_mem_rdata (reads only; writes capture 0); go to RESP.
- RESP (cycle T+2+MEM_LAT):
  - The owner's rvalid=1 with the captured rdata; the other port's rvalid=0.
  - Go to IDLE.
- Latency and throughput:
  - Grant to rvalid = MEM_LAT+2 cycles.
  - Earliest next grant = T+3+MEM_LAT, so throughput is one access per MEM_LAT+3 cycles.
- Grants:
  - Never asserted outside IDLE; requests arriving during a transaction wait.
  - Never both gnt in one cycle.
  - Fairness: continuous requests on both ports alternate I, D, I, D... A lone requester is granted back-to-back.
- Protocol:
  - A requester deasserting req before gnt is legal; no grant is issued.
  - Request fields are sampled only at the grant edge; changes after gnt do not affect the transaction.
  - o_*_rdata hold their last value when rvalid=0.
- Counter width: $clog2(MEM_LAT+1).

Decomposition:
- Package snurisc_mem_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3.
  - Owner constants OWN_I=1'b0, OWN_D=1'b1.
  - Default ADDR_W/DATA_W.
- One natural sub-module, snurisc_rr_arb2: a 2-requester round-robin picker holding last_owner and producing the grant vector. Inputs: req[1:0], advance. It is reused later for the bus interconnect.
- FSM, counter and datapath registers stay in the top of the block.

Test Plan:
- Reset hold, then release with no requests -> all outputs 0, o_busy=0 for 20 cycles. Assert i_reset_n=0 during WAIT -> outputs 0 immediately; no rvalid after release.
- I-read only, addr=0x100, mem returns 0xDEADBEEF, MEM_LAT=2:
  - o_imem_gnt at T.
  - o_mem_en=1, addr=0x100, we=0, be=4'hF at T+1.
  - o_imem_rvalid=1, rdata=0xDEADBEEF at T+4.
- D-write addr=0x200, wdata=0x12345678, be=4'b0011:
  - o_mem_en/we=1 with those values at T+1.
  - o_dmem_rvalid=1, rdata=0 at T+4.
  - No imem activity.
- Both requests held continuously from reset release:
  - First grant goes to I (last_owner=D at reset).
  - Grant sequence is I, D, I, D.
  - Grants spaced exactly 5 cycles apart (MEM_LAT=2).
- D requests during an I transaction's WAIT -> no gnt until IDLE; D granted at T+5.
- MEM_LAT=1 and MEM_LAT=5 builds -> grant to rvalid = 3 and 7 cycles; data matches the memory model.
